// File: rtl/vga_frame_reader.sv
// Frame-buffer reader feeding the VGA timing driver: looks ahead of the driver's pixel
// position, reads RGB332 from the displayed bank, and swaps banks only at the frame boundary.
module vga_frame_reader #(
  parameter int         H_TOTAL    = 795,
  parameter int         V_TOTAL    = 525,
  parameter int         V_VISIBLE  = 480,
  parameter int         IMG_W      = 176,
  parameter int         IMG_H      = 144,
  parameter int         SCALE_LOG2 = 0,
  parameter int         ADDR_W     = 16,
  parameter int         RAM_LAT    = 1,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [9:0]        PIXEL_X,
  input  logic [9:0]        PIXEL_Y,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [7:0]        RAM_DATA,
  output logic [7:0]        PIXEL_COLOR,
  input  logic              FRAME_READY,
  output logic              BUF_SEL,
  output logic              FRAME_DONE,
  output logic              SWAPPED
);
  // Address stage + RAM latency + output register = total lookahead.
  localparam int LOOKAHEAD = RAM_LAT + 2;
  localparam int OFF_W     = ADDR_W - 1;

  logic [10:0]      lx_sum, ly_sum, lx, ly;
  logic             in_win;
  logic [OFF_W-1:0] offset;
  logic [RAM_LAT:0] win_pipe;
  logic             pending;
  logic             boundary;

  always_comb begin
    lx_sum = {1'b0, PIXEL_X} + 11'(LOOKAHEAD);
    ly_sum = {1'b0, PIXEL_Y};
    lx     = lx_sum;
    if (lx_sum >= 11'(H_TOTAL)) begin
      lx     = lx_sum - 11'(H_TOTAL);
      ly_sum = {1'b0, PIXEL_Y} + 11'd1;
    end
    ly     = (ly_sum >= 11'(V_TOTAL)) ? 11'd0 : ly_sum;
    in_win = (lx < 11'(IMG_W << SCALE_LOG2)) && (ly < 11'(IMG_H << SCALE_LOG2));
    offset = OFF_W'((ly >> SCALE_LOG2) * IMG_W + (lx >> SCALE_LOG2));
  end

  assign boundary = (PIXEL_Y == 10'(V_VISIBLE)) && (PIXEL_X == 10'd0);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      RAM_ADDR    <= '0;
      win_pipe    <= '0;
      PIXEL_COLOR <= 8'h00;
    end else begin
      RAM_ADDR    <= {BUF_SEL, offset};
      // in_win rides alongside the RAM access so it lines up with RAM_DATA
      win_pipe    <= (win_pipe << 1) | (RAM_LAT+1)'(in_win);
      PIXEL_COLOR <= win_pipe[RAM_LAT] ? RAM_DATA : BG_COLOR;
    end
  end

  // Swap during vertical blanking so no visible line mixes banks.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      BUF_SEL    <= 1'b0;
      pending    <= 1'b0;
      FRAME_DONE <= 1'b0;
      SWAPPED    <= 1'b0;
    end else begin
      FRAME_DONE <= boundary;
      SWAPPED    <= 1'b0;
      if (boundary && (pending || FRAME_READY)) begin
        BUF_SEL <= ~BUF_SEL;
        SWAPPED <= 1'b1;
        pending <= 1'b0;
      end else if (FRAME_READY) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: two instances (scale 1x and 2x) share one driver; colours,
// addresses and bank-swap pulses are checked against a position-based reference model.
module tb_vga_frame_reader;
  localparam int H = 795, V = 525, VV = 480, IW = 176, IH = 144, AW = 16, LAT = 1, LA = LAT + 2;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [9:0]    px, py;
  logic          fr;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    data0 = 8'h00, data1 = 8'h00, col0, col1;
  logic          buf0, buf1, done0, done1, swp0, swp1;

  int   vectors = 0, miscompares = 0;
  int   good = 0, jx = 0, jy = 0;
  logic jmp = 1'b0;
  logic m_buf = 1'b0, m_pend = 1'b0, e_done = 1'b0, e_swp = 1'b0;

  always #20 CLOCK = ~CLOCK;

  vga_frame_reader #(.SCALE_LOG2(0)) u0 (
    .CLOCK(CLOCK), .RESET(RESET), .PIXEL_X(px), .PIXEL_Y(py), .RAM_ADDR(addr0), .RAM_DATA(data0),
    .PIXEL_COLOR(col0), .FRAME_READY(fr), .BUF_SEL(buf0), .FRAME_DONE(done0), .SWAPPED(swp0));
  vga_frame_reader #(.SCALE_LOG2(1)) u1 (
    .CLOCK(CLOCK), .RESET(RESET), .PIXEL_X(px), .PIXEL_Y(py), .RAM_ADDR(addr1), .RAM_DATA(data1),
    .PIXEL_COLOR(col1), .FRAME_READY(fr), .BUF_SEL(buf1), .FRAME_DONE(done1), .SWAPPED(swp1));

  // Frame-buffer contents: low address byte, scrambled by the high bits so bank/row errors show.
  function automatic logic [7:0] ramf(input logic [15:0] a);
    return a[7:0] ^ {a[15], a[14:8]};
  endfunction

  always @(posedge CLOCK) begin
    data0 <= ramf(addr0);
    data1 <= ramf(addr1);
  end

  function automatic logic [7:0] ref_col(input int x, input int y, input int s, input logic b);
    if (x < (IW << s) && y < (IH << s)) return ramf({b, 15'((y >> s) * IW + (x >> s))});
    return 8'h00;
  endfunction

  function automatic logic [15:0] ref_addr(input int x, input int y, input int s, input logic b);
    int idx, lx, ly;
    idx = (y * H + x + LA) % (H * V);
    lx  = idx % H;
    ly  = idx / H;
    return {b, 15'((ly >> s) * IW + (lx >> s))};
  endfunction

  // One clock: update the bank model from what the DUT sampled, then move the driver.
  task automatic tick();
    @(posedge CLOCK);
    if (RESET) begin
      m_buf = 1'b0; m_pend = 1'b0; e_done = 1'b0; e_swp = 1'b0; good = 0;
    end else begin
      e_done = (py == 10'(VV)) && (px == 10'd0);
      e_swp  = e_done && (m_pend || fr);
      if (e_swp) begin m_buf = ~m_buf; m_pend = 1'b0; end
      else if (fr) m_pend = 1'b1;
      good++;
    end
    #1;
    fr = 1'b0;
    if (jmp) begin
      px = 10'(jx); py = 10'(jy); jmp = 1'b0; good = 0;
    end else if (px == 10'(H - 1)) begin
      px = 10'd0;
      py = (py == 10'(V - 1)) ? 10'd0 : py + 10'd1;
    end else begin
      px = px + 10'd1;
    end
  endtask

  // Jump so the driver reaches (x,y) after running freely long enough to fill the pipeline.
  task automatic goto(input int x, input int y);
    int idx;
    idx = (y * H + x - LA + H * V) % (H * V);
    jx = idx % H; jy = idx / H; jmp = 1'b1;
    tick();
    repeat (LA) tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (4) begin
      jx = 0; jy = 0; jmp = 1'b1;
      tick();
      vectors++;
      if ({col0, col1, buf0, buf1, done0, done1, swp0, swp1, addr0, addr1} !== '0) begin
        miscompares++;
        $display("FAIL reset_state col0=%h col1=%h buf=%b%b done=%b%b swp=%b%b addr=%h/%h want all 0",
                 col0, col1, buf0, buf1, done0, done1, swp0, swp1, addr0, addr1);
      end
    end
    RESET = 1'b0;
    repeat (12) begin
      tick();
      if (good >= LA) begin
        vectors++;
        if (col0 !== ref_col(int'(px), int'(py), 0, m_buf) || col1 !== ref_col(int'(px), int'(py), 1, m_buf)) begin
          miscompares++;
          $display("FAIL post_reset_colour at (%0d,%0d) got %h/%h want %h/%h", px, py, col0, col1,
                   ref_col(int'(px), int'(py), 0, m_buf), ref_col(int'(px), int'(py), 1, m_buf));
        end
      end
    end
    goto(0, 0);
    vectors++;
    if (col0 !== 8'h00) begin
      miscompares++; $display("FAIL frame_start_colour at (0,0) got %h want 00", col0);
    end
    repeat (5) tick();
    vectors++;
    if (col0 !== 8'h05) begin
      miscompares++; $display("FAIL frame_start_colour at (%0d,%0d) got %h want 05", px, py, col0);
    end
  endtask

  task automatic test_window();
    int pts[7][2] = '{'{175, 0}, '{176, 0}, '{0, 143}, '{0, 144}, '{3, 3}, '{351, 287}, '{352, 0}};
    for (int i = 0; i < 7; i++) begin
      goto(pts[i][0], pts[i][1]);
      vectors++;
      if (col0 !== ref_col(pts[i][0], pts[i][1], 0, m_buf)) begin
        miscompares++;
        $display("FAIL window_x1 at (%0d,%0d) got %h want %h", pts[i][0], pts[i][1], col0,
                 ref_col(pts[i][0], pts[i][1], 0, m_buf));
      end
      vectors++;
      if (col1 !== ref_col(pts[i][0], pts[i][1], 1, m_buf)) begin
        miscompares++;
        $display("FAIL window_x2 at (%0d,%0d) got %h want %h", pts[i][0], pts[i][1], col1,
                 ref_col(pts[i][0], pts[i][1], 1, m_buf));
      end
    end
  endtask

  task automatic test_lookahead_wrap();
    int x, y;
    jx = 793; jy = 10; jmp = 1'b1; tick(); tick();
    vectors++;
    if (addr0 !== {m_buf, 15'd1937}) begin
      miscompares++; $display("FAIL wrap_line addr got %h want %h", addr0, {m_buf, 15'd1937});
    end
    jx = 793; jy = 524; jmp = 1'b1; tick(); tick();
    vectors++;
    if (addr0 !== {m_buf, 15'd1}) begin
      miscompares++; $display("FAIL wrap_frame addr got %h want %h", addr0, {m_buf, 15'd1});
    end
    repeat (20) begin
      x = int'($urandom_range(0, H - 1)); y = int'($urandom_range(0, V - 1));
      jx = x; jy = y; jmp = 1'b1; tick(); tick();
      vectors++;
      if (addr0 !== ref_addr(x, y, 0, m_buf) || addr1 !== ref_addr(x, y, 1, m_buf)) begin
        miscompares++;
        $display("FAIL rand_addr at (%0d,%0d) got %h/%h want %h/%h", x, y, addr0, addr1,
                 ref_addr(x, y, 0, m_buf), ref_addr(x, y, 1, m_buf));
      end
    end
  endtask

  task automatic test_random_colour();
    repeat (25) begin
      goto(int'($urandom_range(0, 399)), int'($urandom_range(0, 299)));
      repeat (6) begin
        vectors++;
        if (col0 !== ref_col(int'(px), int'(py), 0, m_buf) || col1 !== ref_col(int'(px), int'(py), 1, m_buf)) begin
          miscompares++;
          $display("FAIL rand_colour at (%0d,%0d) got %h/%h want %h/%h", px, py, col0, col1,
                   ref_col(int'(px), int'(py), 0, m_buf), ref_col(int'(px), int'(py), 1, m_buf));
        end
        tick();
      end
    end
  endtask

  task automatic test_swap();
    int sw, dn;
    goto(100, 200);
    fr = 1'b1; tick();
    for (int f = 0; f < 2; f++) begin
      sw = 0; dn = 0;
      jx = 790; jy = 479; jmp = 1'b1; tick();
      repeat (12) begin
        tick();
        sw += int'(swp0); dn += int'(done0);
        vectors++;
        if ({done0, swp0, buf0, done1, swp1, buf1} !== {e_done, e_swp, m_buf, e_done, e_swp, m_buf}) begin
          miscompares++;
          $display("FAIL swap_pulses frame%0d at (%0d,%0d) got done=%b swp=%b buf=%b want %b %b %b",
                   f, px, py, done0, swp0, buf0, e_done, e_swp, m_buf);
        end
      end
      vectors++;
      if (sw !== 1 - f || dn !== 1 || buf0 !== 1'b1) begin
        miscompares++;
        $display("FAIL swap_frame%0d swaps=%0d dones=%0d buf=%b want %0d 1 1", f, sw, dn, buf0, 1 - f);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sw;
    // FRAME_READY coincident with the boundary swaps immediately (bank 1 -> 0)
    jx = 0; jy = VV; jmp = 1'b1; tick();
    fr = 1'b1; tick();
    vectors++;
    if ({swp0, done0, buf0} !== 3'b110 || m_buf !== 1'b0) begin
      miscompares++; $display("FAIL ready_at_boundary got swp=%b done=%b buf=%b want 1 1 0", swp0, done0, buf0);
    end
    tick();
    vectors++;
    if ({swp0, done0} !== 2'b00) begin
      miscompares++; $display("FAIL pulse_width got swp=%b done=%b want 0 0", swp0, done0);
    end
    // two requests in one frame give one toggle
    goto(10, 100);
    fr = 1'b1; tick();
    repeat (5) tick();
    fr = 1'b1; tick();
    sw = 0;
    jx = 790; jy = 479; jmp = 1'b1; tick();
    repeat (12) begin
      tick(); sw += int'(swp0);
    end
    vectors++;
    if (sw !== 1 || buf0 !== 1'b1 || buf0 !== m_buf) begin
      miscompares++; $display("FAIL double_ready swaps=%0d buf=%b want 1 1", sw, buf0);
    end
    // reset discards a pending request
    goto(10, 100);
    fr = 1'b1; tick();
    RESET = 1'b1; tick(); tick();
    RESET = 1'b0;
    vectors++;
    if (buf0 !== 1'b0 || buf1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_buf got %b/%b want 0", buf0, buf1);
    end
    sw = 0;
    jx = 790; jy = 479; jmp = 1'b1; tick();
    repeat (12) begin
      tick(); sw += int'(swp0);
      vectors++;
      if ({done0, swp0, buf0} !== {e_done, e_swp, m_buf}) begin
        miscompares++;
        $display("FAIL reset_pending at (%0d,%0d) got done=%b swp=%b buf=%b want %b %b %b",
                 px, py, done0, swp0, buf0, e_done, e_swp, m_buf);
      end
    end
    vectors++;
    if (sw !== 0 || buf0 !== 1'b0) begin
      miscompares++; $display("FAIL reset_pending_swap swaps=%0d buf=%b want 0 0", sw, buf0);
    end
  endtask

  initial begin
    RESET = 1'b1; px = 10'd0; py = 10'd0; fr = 1'b0;
    test_reset();
    test_window();
    test_lookahead_wrap();
    test_random_colour();
    test_swap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
